// File: rtl/incident_uart_tx.sv
// incident_uart_tx
//   Queues incident reports from the signal detection block and sends each one
//   to the K64 controller as a framed byte sequence on a UART 8N1 line.
//   Frame: HEADER, b0, b1, b2, b3 [, CHK = (b0+b1+b2+b3) mod 256].
//
//   Optional feature macro: INCIDENT_TX_CHECKSUM_EN
//     defined   -> 6-byte frames with the CHK byte appended after b3
//     undefined -> 5-byte frames, no checksum adder
//
// Ports
//   clk              system clock
//   rst              asynchronous active-high reset
//   incident_inform  report strobe, captured on its rising edge
//   incident_b0..b3  report bytes, sampled with the strobe edge
//   ovf_clr          synchronous clear of the sticky overflow flag
//   tx               UART line (idle high, flop driven)
//   busy             high from frame load until the last stop bit ends
//   fifo_level       number of stored reports not yet loaded
//   overflow         sticky, set when a report is dropped
module incident_uart_tx #(
  parameter int         CLK_DIV         = 434,
  parameter int         FIFO_DEPTH_LOG2 = 2,
  parameter logic [7:0] HEADER          = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     incident_inform,
  input  logic [7:0]               incident_b0,
  input  logic [7:0]               incident_b1,
  input  logic [7:0]               incident_b2,
  input  logic [7:0]               incident_b3,
  input  logic                     ovf_clr,
  output logic                     tx,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level,
  output logic                     overflow
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0]   DEPTH_L  = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0]   LVL_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);
  localparam logic [15:0]                DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0]                DIV_PRE  = 16'(CLK_DIV - 2);

`ifdef INCIDENT_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;

  function automatic logic [7:0] frame_checksum(input logic [31:0] f);
    return f[7:0] + f[15:8] + f[23:16] + f[31:24];
  endfunction
`else
  localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

  // Byte idx of the frame built around report f ({b3,b2,b1,b0}).
  function automatic logic [7:0] byte_sel(input logic [31:0] f, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HEADER;
      3'd1:    b = f[7:0];
      3'd2:    b = f[15:8];
      3'd3:    b = f[23:16];
      3'd4:    b = f[31:24];
`ifdef INCIDENT_TX_CHECKSUM_EN
      3'd5:    b = frame_checksum(f);
`endif
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t                     state_r, state_n_s;
  logic [15:0]                cnt_r, cnt_n_s;
  logic [2:0]                 bit_r, bit_n_s;
  logic [2:0]                 byte_r, byte_n_s;
  logic [31:0]                frame_r;
  logic                       inf_d_r;
  logic [31:0]                mem_r [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;

  logic       push_s, push_ok_s, drop_s, pop_s;
  logic       bit_end_s, fifo_nonempty_s, tx_n_s;
  logic [7:0] cur_byte_s;

  assign push_s          = incident_inform & ~inf_d_r;
  assign fifo_nonempty_s = |fifo_level;
  assign bit_end_s       = (cnt_r == DIV_LAST);
  assign push_ok_s       = push_s & ((fifo_level < DEPTH_L) | pop_s);
  assign drop_s          = push_s & ~push_ok_s;

  // Transmit FSM: next state, baud/bit/byte counters, FIFO pop and next line level.
  always_comb begin
    state_n_s  = state_r;
    cnt_n_s    = cnt_r;
    bit_n_s    = bit_r;
    byte_n_s   = byte_r;
    pop_s      = 1'b0;
    cur_byte_s = 8'hFF;
    tx_n_s     = 1'b1;
    case (state_r)
      S_IDLE: begin
        cnt_n_s = 16'd0;
        if (fifo_nonempty_s) begin
          state_n_s = S_LOAD;
          pop_s     = 1'b1;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_LOAD: begin
        state_n_s = S_START;
        cnt_n_s   = 16'd0;
        bit_n_s   = 3'd0;
        byte_n_s  = 3'd0;
      end
      S_START: begin
        if (bit_end_s) begin
          state_n_s = S_DATA;
          cnt_n_s   = 16'd0;
          bit_n_s   = 3'd0;
        end else begin
          cnt_n_s = cnt_r + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_n_s = 16'd0;
          if (bit_r == 3'd7) begin
            state_n_s = S_STOP;
          end else begin
            bit_n_s = bit_r + 3'd1;
          end
        end else begin
          cnt_n_s = cnt_r + 16'd1;
        end
      end
      S_STOP: begin
        if (byte_r == LAST_BYTE) begin
          // When chaining, the one-cycle LOAD (tx high) is the final cycle of the
          // stop bit, so the next start bit follows the stop bit with no gap.
          if (fifo_nonempty_s && (cnt_r == DIV_PRE)) begin
            state_n_s = S_LOAD;
            pop_s     = 1'b1;
            cnt_n_s   = 16'd0;
          end else if (bit_end_s) begin
            state_n_s = S_IDLE;
            cnt_n_s   = 16'd0;
          end else begin
            cnt_n_s = cnt_r + 16'd1;
          end
        end else begin
          if (bit_end_s) begin
            state_n_s = S_START;
            cnt_n_s   = 16'd0;
            byte_n_s  = byte_r + 3'd1;
          end else begin
            cnt_n_s = cnt_r + 16'd1;
          end
        end
      end
      default: begin
        state_n_s = S_IDLE;
        cnt_n_s   = 16'd0;
      end
    endcase

    // tx is registered, so it is derived from the state about to be entered.
    cur_byte_s = byte_sel(frame_r, byte_n_s);
    case (state_n_s)
      S_START: tx_n_s = 1'b0;
      S_DATA:  tx_n_s = cur_byte_s[bit_n_s];
      default: tx_n_s = 1'b1;
    endcase
  end

  // Report storage; no reset needed since only entries below fifo_level are read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= {incident_b3, incident_b2, incident_b1, incident_b0};
    end
  end

  // State, counters, FIFO bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= 16'd0;
      bit_r      <= 3'd0;
      byte_r     <= 3'd0;
      frame_r    <= 32'd0;
      inf_d_r    <= 1'b0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      bit_r   <= bit_n_s;
      byte_r  <= byte_n_s;
      inf_d_r <= incident_inform;
      tx      <= tx_n_s;
      busy    <= (state_n_s != S_IDLE);
      if (pop_s) begin
        frame_r  <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_s})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
      // A drop in the same cycle as ovf_clr keeps the flag set.
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_incident_uart_tx.sv
// tb_incident_uart_tx
//   Directed bench for incident_uart_tx with CLK_DIV=4, FIFO_DEPTH_LOG2=2.
//   A UART receiver process decodes tx into bytes and start-bit cycle stamps.
module tb_incident_uart_tx;

  localparam int DIV      = 4;
  localparam int BYTE_CYC = 10 * DIV;
`ifdef INCIDENT_TX_CHECKSUM_EN
  localparam int         NB      = 6;
  localparam logic [7:0] T2_LAST = 8'hFC;
`else
  localparam int         NB      = 5;
  localparam logic [7:0] T2_LAST = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       inform;
  logic [7:0] b0, b1, b2, b3;
  logic       ovf_clr;
  logic       tx, busy, overflow;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int framing_errs = 0;
  logic [7:0] rx_q[$];
  int         start_q[$];
  logic [7:0] t1_exp [6] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};

  incident_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH_LOG2(2), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .incident_inform(inform),
    .incident_b0(b0), .incident_b1(b1), .incident_b2(b2), .incident_b3(b3),
    .ovf_clr(ovf_clr), .tx(tx), .busy(busy), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART receiver: start detected on its first cycle, bits sampled mid-bit.
  int         rx_t0;
  logic [7:0] rx_d;
  always begin
    @(negedge clk);
    if (rst === 1'b0 && tx === 1'b0) begin
      rx_t0 = cyc;
      repeat (DIV + DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        rx_d[i] = tx;
        if (i < 7) repeat (DIV) @(negedge clk);
      end
      repeat (DIV) @(negedge clk);
      if (tx !== 1'b1) framing_errs++;
      rx_q.push_back(rx_d);
      start_q.push_back(rx_t0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while ((busy !== 1'b0 || fifo_level !== 3'd0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, (n < max_cyc) ? 32'd1 : 32'd0, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    start_q.delete();
  endtask

  initial begin
    int n, maxl, bad;
    rst = 1'b1; inform = 1'b0; ovf_clr = 1'b0;
    b0 = 8'h00; b1 = 8'h00; b2 = 8'h00; b3 = 8'h00;
    #1;
    check_eq("rst_tx_async", tx, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_level", fifo_level, 3'd0);
    check_eq("rst_ovf", overflow, 1'b0);

    // Single report 01,02,03,04; inform rises in cycle E.
    clear_rx();
    b0 = 8'h01; b1 = 8'h02; b2 = 8'h03; b3 = 8'h04; inform = 1'b1;
    @(negedge clk);
    inform = 1'b0;
    check_eq("t1_level_e1", fifo_level, 3'd1);
    check_eq("t1_busy_e1", busy, 1'b0);
    @(negedge clk);
    check_eq("t1_busy_e2", busy, 1'b1);
    check_eq("t1_level_e2", fifo_level, 3'd0);
    @(negedge clk);
    check_eq("t1_start_e3", tx, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("t1_frame_len", n, NB * BYTE_CYC);
    repeat (4) @(negedge clk);
    check_eq("t1_nbytes", rx_q.size(), NB);
    for (int i = 0; i < NB; i++) check_eq("t1_byte", rx_q[i], t1_exp[i]);
    check_eq("t1_framing", framing_errs, 0);

    // Strobe held high for 100 cycles yields one frame.
    clear_rx();
    b0 = 8'hFF; b1 = 8'hFF; b2 = 8'hFF; b3 = 8'hFF; inform = 1'b1; maxl = 0;
    repeat (100) begin
      @(negedge clk);
      if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
    end
    inform = 1'b0;
    wait_idle("t2_idle", 400);
    check_eq("t2_nbytes", rx_q.size(), NB);
    check_eq("t2_b0", rx_q[1], 8'hFF);
    check_eq("t2_last", rx_q[NB-1], T2_LAST);
    check_eq("t2_maxlevel", maxl, 1);

    // Six strobes two cycles apart: 1 loaded, 4 stored, 6th dropped.
    clear_rx();
    maxl = 0; b1 = 8'h00; b2 = 8'h00; b3 = 8'h00;
    for (int i = 0; i < 12; i++) begin
      inform = (i % 2 == 0);
      b0 = 8'(i / 2 + 1);
      @(negedge clk);
      if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
    end
    inform = 1'b0;
    check_eq("t3_ovf_set", overflow, 1'b1);
    check_eq("t3_maxlevel", maxl, 4);
    wait_idle("t3_idle", 5 * NB * BYTE_CYC + 100);
    check_eq("t3_nbytes", rx_q.size(), 5 * NB);
    for (int k = 0; k < 5; k++) begin
      check_eq("t3_hdr", rx_q[k*NB], 8'hA5);
      check_eq("t3_n", rx_q[k*NB+1], 8'(k + 1));
    end
    bad = 0;
    for (int j = 1; j < start_q.size(); j++)
      if (start_q[j] - start_q[j-1] != BYTE_CYC) bad++;
    check_eq("t3_gaps", bad, 0);
    check_eq("t3_ovf_sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_eq("t3_ovf_clr", overflow, 1'b0);

    // Full FIFO, push lands in the same cycle as the chained LOAD pop.
    clear_rx();
    for (int i = 0; i <= 1 + NB * BYTE_CYC; i++) begin
      inform = (i < 10 && i % 2 == 0) || (i == 1 + NB * BYTE_CYC);
      b0 = (i < 10) ? 8'(i / 2 + 1) : 8'h77;
      @(negedge clk);
    end
    inform = 1'b0;
    check_eq("t4_level", fifo_level, 3'd4);
    check_eq("t4_ovf", overflow, 1'b0);
    check_eq("t4_busy", busy, 1'b1);
    wait_idle("t4_idle", 6 * NB * BYTE_CYC + 200);
    check_eq("t4_nbytes", rx_q.size(), 6 * NB);
    check_eq("t4_n5", rx_q[4*NB+1], 8'h05);
    check_eq("t4_pushed", rx_q[5*NB+1], 8'h77);
    check_eq("t4_ovf_end", overflow, 1'b0);

    // Reset during the data bits of b1 (b1 = 00, so tx is low there).
    clear_rx();
    b1 = 8'h00; b2 = 8'h03; b3 = 8'h04;
    for (int i = 0; i < 93; i++) begin
      inform = (i == 0) || (i == 20);
      b0 = (i < 20) ? 8'h01 : 8'h55;
      @(negedge clk);
    end
    check_eq("t5_tx_pre", tx, 1'b0);
    check_eq("t5_level_pre", fifo_level, 3'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_tx_async", tx, 1'b1);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_level", fifo_level, 3'd0);
    check_eq("t5_ovf", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
      if (busy !== 1'b0) bad++;
    end
    check_eq("t5_quiet", bad, 0);
    check_eq("t5_level_post", fifo_level, 3'd0);
    clear_rx();
    b0 = 8'h11; b1 = 8'h22; b2 = 8'h33; b3 = 8'h44; inform = 1'b1;
    @(negedge clk);
    inform = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle("t5_idle", 400);
    check_eq("t5_nbytes", rx_q.size(), NB);
    check_eq("t5_hdr", rx_q[0], 8'hA5);
    check_eq("t5_b0", rx_q[1], 8'h11);
    check_eq("t5_b3", rx_q[4], 8'h44);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
